acc_datapath_gen: RTL and testbench

Parametrised accumulator datapath, the successor to the fixed single-cycle control-flag datapath. Accepts one decoded operation per handshake and executes register-reference ops in one cycle. Memory-reference ops (optionally indirect, including ISZ read-modify-write) run through a memory req/ack handshake. Sits between the instruction decoder/sequencer and the unified memory port.

---
 rtl/acc_dp_pkg.sv | 15 +
 rtl/acc_datapath_gen_if.sv | 26 ++
 rtl/acc_dp_alu.sv | 34 +++
 rtl/acc_datapath_gen.sv | 83 ++++++++
 tb/tb_acc_datapath_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/acc_dp_pkg.sv
// acc_dp_pkg: shared op encoding, FSM states and decode helpers for the accumulator datapath
package acc_dp_pkg;
  localparam int OPC_W = 4;
  typedef enum logic [OPC_W-1:0] {
    NOP, CLA, CLE, CMA, CME, CIR, CIL, INC, AND, ADD, LDA, STA, BUN, ISZ
  } op_t;
  typedef enum logic [2:0] {IDLE, IND, RD, WR, DONE} state_t;
  function automatic logic is_mem_ref(op_t op);
    return op inside {AND, ADD, LDA, STA, BUN, ISZ};
  endfunction
  // first state once the effective address is known
  function automatic state_t first_step(op_t op);
    return (op == BUN) ? DONE : (op == STA) ? WR : RD;
  endfunction
endpackage

// File: rtl/acc_datapath_gen_if.sv
// acc_datapath_gen_if: decoder op handshake plus unified memory port; slave is the datapath side
interface acc_datapath_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int OP_W = 4
);
  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_code;
  logic [ADDR_W-1:0] op_addr;
  logic              op_ind;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  modport master (
    output op_valid, op_code, op_addr, op_ind, mem_rdata, mem_ack,
    input  op_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  op_valid, op_code, op_addr, op_ind, mem_rdata, mem_ack,
    output op_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/acc_dp_alu.sv
// acc_dp_alu: combinational next-{e,ac} for register ops and memory operand ops
module acc_dp_alu
  import acc_dp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  op_t               i_op,
  input  logic [DATA_W-1:0] i_ac,
  input  logic              i_e,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_ac,
  output logic              o_e
);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
  logic [DATA_W:0] w_sum;
  assign w_sum = {1'b0, i_ac} + {1'b0, i_d};
  always_comb begin
    o_ac = i_ac;
    o_e  = i_e;
    case (i_op)
      CLA: o_ac = '0;
      CLE: o_e = 1'b0;
      CMA: o_ac = ~i_ac;
      CME: o_e = ~i_e;
      CIR: {o_ac, o_e} = {i_e, i_ac};
      CIL: {o_e, o_ac} = {i_ac, i_e};
      INC: o_ac = i_ac + ONE;
      AND: o_ac = i_ac & i_d;
      ADD: {o_e, o_ac} = w_sum;
      LDA: o_ac = i_d;
      default: ;
    endcase
  end
endmodule

// File: rtl/acc_datapath_gen.sv
// acc_datapath_gen: accumulator datapath; register ops in one cycle, memory-reference ops via req/ack
module acc_datapath_gen
  import acc_dp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int OP_W = OPC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  acc_datapath_gen_if.slave bus,
  output logic [DATA_W-1:0] o_ac,
  output logic              o_e,
  output logic              o_skip,
  output logic              o_br_valid,
  output logic [ADDR_W-1:0] o_br_target,
  output logic              o_busy
);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
  state_t            r_state, w_next;
  op_t               r_op, w_op, w_alu_op;
  logic [OP_W-1:0]   w_code;
  logic [ADDR_W-1:0] r_ea;
  logic [DATA_W-1:0] r_ac, r_wdata, w_alu_ac;
  logic              r_e, r_req, w_alu_e, w_acc, w_ack;
  assign w_code   = bus.op_code;
  assign w_op     = op_t'(w_code);
  assign w_acc    = bus.op_valid && bus.op_ready;
  assign w_ack    = r_req && bus.mem_ack;
  assign w_alu_op = (r_state == IDLE) ? w_op : r_op;
  acc_dp_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op(w_alu_op),
    .i_ac(r_ac),
    .i_e (r_e),
    .i_d (bus.mem_rdata),
    .o_ac(w_alu_ac),
    .o_e (w_alu_e)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = (w_acc && is_mem_ref(w_op)) ? (bus.op_ind ? IND : first_step(w_op)) : IDLE;
      IND:  w_next = w_ack ? first_step(r_op) : IND;
      RD:   w_next = w_ack ? ((r_op == ISZ) ? WR : DONE) : RD;
      WR:   w_next = w_ack ? DONE : WR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= NOP;
      r_ea    <= '0;
      r_ac    <= '0;
      r_e     <= 1'b0;
      r_wdata <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      // request rises one cycle after entering a memory state, so consecutive accesses are separated
      r_req <= r_req ? !bus.mem_ack : (r_state inside {IND, RD, WR});
      if (w_acc) begin
        r_op    <= w_op;
        r_ea    <= bus.op_addr;
        r_wdata <= r_ac;
      end
      if (r_state == IND && w_ack) r_ea <= bus.mem_rdata[ADDR_W-1:0];
      if (r_state == RD && w_ack) r_wdata <= bus.mem_rdata + ONE;
      if ((w_acc && !is_mem_ref(w_op)) || (r_state == RD && w_ack)) {r_e, r_ac} <= {w_alu_e, w_alu_ac};
    end
  end
  assign bus.op_ready  = (r_state == IDLE);
  assign bus.mem_req   = r_req;
  assign bus.mem_we    = (r_state == WR);
  assign bus.mem_addr  = r_ea;
  assign bus.mem_wdata = r_wdata;
  assign o_ac          = r_ac;
  assign o_e           = r_e;
  assign o_skip        = (r_state == DONE) && (r_op == ISZ) && (r_wdata == '0);
  assign o_br_valid    = (r_state == DONE) && (r_op == BUN);
  assign o_br_target   = r_ea;
  assign o_busy        = (r_state != IDLE);
endmodule

// File: tb/tb_acc_datapath_gen.sv
// tb_acc_datapath_gen: directed and randomized checks against a behavioural accumulator/memory model
module tb_acc_datapath_gen;
  import acc_dp_pkg::*;
  typedef struct packed {logic we; logic [11:0] a; logic [15:0] d;} acc_t;
  logic clk = 0;
  logic rst_n = 1;
  logic [15:0] ac;
  logic [11:0] br_target;
  logic e, skip, br_valid, busy;
  acc_datapath_gen_if bus();
  acc_datapath_gen dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .o_ac(ac), .o_e(e), .o_skip(skip),
    .o_br_valid(br_valid), .o_br_target(br_target), .o_busy(busy)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];
  acc_t got_q[$], exp_q[$];
  int checks = 0, failures = 0, ack_dly = 0, wcnt = 0;
  int exp_busy, exp_skip, exp_br;
  logic [11:0] exp_tgt, h_addr;
  logic [15:0] m_ac = 0;
  logic m_e = 0, h_we;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic acc_t mk(input logic we, input logic [11:0] a, input logic [15:0] d);
    return {we, a, d};
  endfunction
  task automatic poke(input logic [11:0] a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask
  // memory slave: acks after ack_dly waiting cycles, logs every completed access
  initial begin
    bus.mem_ack = 0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 0;
      if (!bus.mem_req) wcnt = 0;
      else begin
        if (wcnt == 0) begin
          h_addr = bus.mem_addr;
          h_we = bus.mem_we;
        end else begin
          chk("hold_addr", 32'(bus.mem_addr), 32'(h_addr));
          chk("hold_we", 32'(bus.mem_we), 32'(h_we));
        end
        if (wcnt >= ack_dly) begin
          bus.mem_ack = 1;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr];
          got_q.push_back(mk(bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr]));
          wcnt = 0;
        end else wcnt++;
      end
    end
  end
  // reference: applies one op to the model state and predicts accesses, pulses and busy cycles
  task automatic model(input op_t op, input logic [11:0] a, input bit ind, input int dly);
    logic [11:0] ea;
    logic [15:0] d;
    logic [16:0] sum;
    ea = a;
    exp_q.delete();
    exp_skip = 0;
    exp_br = 0;
    exp_tgt = '0;
    exp_busy = 0;
    if (!(op inside {AND, ADD, LDA, STA, BUN, ISZ})) begin
      d = m_ac;
      case (op)
        CLA: m_ac = 16'd0;
        CLE: m_e = 1'b0;
        CMA: m_ac = ~m_ac;
        CME: m_e = ~m_e;
        CIR: begin m_ac = (d >> 1) | (16'(m_e) << 15); m_e = d[0]; end
        CIL: begin m_ac = (d << 1) | 16'(m_e); m_e = d[15]; end
        INC: m_ac = m_ac + 16'd1;
        default: ;
      endcase
      return;
    end
    if (ind) begin
      exp_q.push_back(mk(1'b0, a, ref_mem[a]));
      ea = ref_mem[a][11:0];
    end
    d = ref_mem[ea];
    case (op)
      AND: m_ac = m_ac & d;
      ADD: begin sum = 17'(m_ac) + 17'(d); m_ac = sum[15:0]; m_e = sum[16]; end
      LDA: m_ac = d;
      STA: ref_mem[ea] = m_ac;
      BUN: begin exp_br = 1; exp_tgt = ea; end
      ISZ: begin ref_mem[ea] = d + 16'd1; exp_skip = (ref_mem[ea] == 16'd0) ? 1 : 0; end
      default: ;
    endcase
    if (op inside {AND, ADD, LDA, ISZ}) exp_q.push_back(mk(1'b0, ea, d));
    if (op inside {STA, ISZ}) exp_q.push_back(mk(1'b1, ea, ref_mem[ea]));
    exp_busy = 2 * exp_q.size() + 1 + exp_q.size() * dly;
  endtask
  task automatic do_op(input op_t op, input logic [11:0] a, input bit ind, input int dly);
    int busy_n, n_skip, n_br;
    logic [11:0] tgt;
    model(op, a, ind, dly);
    ack_dly = dly;
    got_q.delete();
    busy_n = 0;
    n_skip = 0;
    n_br = 0;
    tgt = '0;
    @(negedge clk);
    chk("ready_before", 32'(bus.op_ready), 1);
    bus.op_valid = 1;
    bus.op_code = op;
    bus.op_addr = a;
    bus.op_ind = ind;
    @(negedge clk);
    bus.op_valid = 0;
    bus.op_code = $urandom_range(0, 13);
    forever begin
      if (skip) n_skip++;
      if (br_valid) begin n_br++; tgt = br_target; end
      if (bus.op_ready || busy_n >= 300) break;
      busy_n++;
      @(negedge clk);
    end
    chk($sformatf("busy_cycles_%s", op.name()), busy_n, exp_busy);
    chk($sformatf("ac_%s", op.name()), 32'(ac), 32'(m_ac));
    chk($sformatf("e_%s", op.name()), 32'(e), 32'(m_e));
    chk("skip_pulses", n_skip, exp_skip);
    chk("br_pulses", n_br, exp_br);
    if (exp_br != 0) chk("br_target", 32'(tgt), 32'(exp_tgt));
    chk("n_accesses", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("access", 32'(got_q[i]), 32'(exp_q[i]));
  endtask
  initial begin
    bus.op_valid = 0;
    bus.op_code = '0;
    bus.op_addr = '0;
    bus.op_ind = 0;
    for (int i = 0; i < 4096; i++) poke(12'(i), 16'($urandom));
    #3 rst_n = 0;
    #10;
    chk("rst_ac", 32'(ac), 0);
    chk("rst_e", 32'(e), 0);
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_ready", 32'(bus.op_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    poke(12'h100, 16'h1234);
    do_op(LDA, 12'h100, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst2_ac", 32'(ac), 0);
    chk("rst2_e", 32'(e), 0);
    chk("rst2_req", 32'(bus.mem_req), 0);
    chk("rst2_ready", 32'(bus.op_ready), 1);
    m_ac = 0;
    m_e = 0;
    @(negedge clk);
    rst_n = 1;
    poke(12'h101, 16'h8001);
    do_op(LDA, 12'h101, 0, 0);
    do_op(CLE, 12'h000, 0, 0);
    do_op(CIL, 12'h000, 0, 0);
    chk("cil_const", 32'({e, ac}), 32'h1_0002);
    do_op(CIR, 12'h000, 0, 0);
    chk("cir_const", 32'({e, ac}), 32'h0_8001);
    poke(12'h010, 16'h0002);
    poke(12'h102, 16'hFFFF);
    do_op(LDA, 12'h102, 0, 0);
    do_op(ADD, 12'h010, 0, 0);
    chk("add_const", 32'({e, ac}), 32'h1_0001);
    do_op(LDA, 12'h102, 0, 0);
    do_op(INC, 12'h000, 0, 0);
    chk("inc_const", 32'({e, ac}), 32'h1_0000);
    poke(12'h020, 16'hF050);
    poke(12'h050, 16'hABCD);
    do_op(LDA, 12'h020, 1, 3);
    chk("ind_lda_ac", 32'(ac), 32'hABCD);
    do_op(LDA, 12'h020, 1, 0);
    chk("lat_ind_lda", exp_busy, 5);
    do_op(LDA, 12'h050, 0, 0);
    chk("lat_lda", exp_busy, 3);
    poke(12'h030, 16'hFFFF);
    poke(12'h031, 16'h0005);
    do_op(ISZ, 12'h030, 0, 0);
    chk("isz_wrap_mem", 32'(mem[12'h030]), 0);
    chk("lat_isz", exp_busy, 5);
    do_op(ISZ, 12'h031, 0, 0);
    chk("isz_mem", 32'(mem[12'h031]), 6);
    poke(12'h040, 16'h0123);
    do_op(BUN, 12'h040, 1, 1);
    do_op(BUN, 12'h345, 0, 0);
    // abandon an STA while its write is outstanding
    poke(12'h200, 16'h5A5A);
    ack_dly = 1000;
    @(negedge clk);
    bus.op_valid = 1;
    bus.op_code = STA;
    bus.op_addr = 12'h200;
    bus.op_ind = 0;
    @(negedge clk);
    bus.op_valid = 0;
    for (int i = 0; i < 20 && !(bus.mem_req && bus.mem_we); i++) @(negedge clk);
    chk("sta_wr_req", 32'(bus.mem_req && bus.mem_we), 1);
    #2 rst_n = 0;
    #1;
    chk("sta_rst_req", 32'(bus.mem_req), 0);
    chk("sta_rst_ready", 32'(bus.op_ready), 1);
    chk("sta_rst_ac", 32'(ac), 0);
    m_ac = 0;
    m_e = 0;
    @(negedge clk);
    rst_n = 1;
    ack_dly = 0;
    chk("sta_no_wb", 32'(mem[12'h200]), 32'h5A5A);
    for (int n = 0; n < 300; n++)
      do_op(op_t'($urandom_range(0, 13)), 12'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)), $urandom_range(0, 3));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
